// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker
//   Converts writeback-stage retirements into registered, single-cycle RVFI
//   commit packets carrying a monotonic retirement order. Writes to x0 are
//   masked in the packet. A run of HALT_REPEAT consecutive retiring self-loops
//   (next_pc == pc, same pc each time) raises a sticky halt, after which
//   nothing else retires until rst.
//
// Configuration macro: COMMIT_SHADOW_REGS_EN
//   defined   : a 32 x XLEN shadow register file is kept and driven on regs
//   undefined : no storage, regs is tied to zero
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wb_valid, wb_stall  WB holds a real instruction / WB frozen this cycle
//   wb_inst, wb_pc, wb_next_pc, wb_rd_we, wb_rd_addr, wb_rd_wdata
//                       retiring instruction fields
//   commit, order       one-cycle retirement pulse and its order number
//   pc_rdata, pc_wdata, insn, rd_addr, rd_wdata
//                       registered packet, held while commit is low
//   halt                sticky terminal-loop indication
//   regs                shadow register file, entry i at regs[i*XLEN +: XLEN]
module rvfi_commit_tracker #(
  parameter int XLEN        = 32,
  parameter int ORDER_W     = 64,
  parameter int HALT_REPEAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic                 wb_stall,
  input  logic [31:0]          wb_inst,
  input  logic [XLEN-1:0]      wb_pc,
  input  logic [XLEN-1:0]      wb_next_pc,
  input  logic                 wb_rd_we,
  input  logic [4:0]           wb_rd_addr,
  input  logic [XLEN-1:0]      wb_rd_wdata,
  output logic                 commit,
  output logic [ORDER_W-1:0]   order,
  output logic [XLEN-1:0]      pc_rdata,
  output logic [XLEN-1:0]      pc_wdata,
  output logic [31:0]          insn,
  output logic [4:0]           rd_addr,
  output logic [XLEN-1:0]      rd_wdata,
  output logic                 halt,
  output logic [32*XLEN-1:0]   regs
);

  localparam int CNT_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {RUN, SPIN, HALTED} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [XLEN-1:0]    spin_pc, spin_pc_next;
  logic [ORDER_W-1:0] order_cnt;

  logic retire;
  logic self_loop;
  logic rd_live;

  assign retire    = wb_valid & ~wb_stall & (state != HALTED);
  assign self_loop = (wb_next_pc == wb_pc);
  assign rd_live   = wb_rd_we & (wb_rd_addr != 5'd0);
  assign halt      = (state == HALTED);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    spin_pc_next = spin_pc;
    case (state)
      RUN: begin
        if (retire && self_loop) begin
          if (HALT_REPEAT == 1) begin
            state_next = HALTED;
          end else begin
            state_next   = SPIN;
            cnt_next     = CNT_W'(1);
            spin_pc_next = wb_pc;
          end
        end
      end
      SPIN: begin
        if (retire) begin
          if (self_loop && (wb_pc == spin_pc)) begin
            cnt_next = cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == CNT_W'(HALT_REPEAT)) state_next = HALTED;
          end else if (self_loop) begin
            // A loop at a different pc starts a fresh run.
            cnt_next     = CNT_W'(1);
            spin_pc_next = wb_pc;
          end else begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end
      end
      HALTED:  ;
      default: state_next = RUN;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      spin_pc   <= '0;
      order_cnt <= '0;
      commit    <= 1'b0;
      order     <= '0;
      pc_rdata  <= '0;
      pc_wdata  <= '0;
      insn      <= '0;
      rd_addr   <= '0;
      rd_wdata  <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      spin_pc <= spin_pc_next;
      commit  <= retire;
      if (retire) begin
        order     <= order_cnt;
        order_cnt <= order_cnt + ORDER_W'(1);
        pc_rdata  <= wb_pc;
        pc_wdata  <= wb_next_pc;
        insn      <= wb_inst;
        rd_addr   <= wb_rd_we ? wb_rd_addr : 5'd0;
        rd_wdata  <= rd_live ? wb_rd_wdata : '0;
      end
    end
  end

`ifdef COMMIT_SHADOW_REGS_EN
  // x0 has no storage; it reads as zero.
  logic [XLEN-1:0] shadow [1:31];

  // NOTE: this array is cleared on reset because the register view must read
  // zero after rst; that forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) shadow[i] <= '0;
    end else if (retire && rd_live) begin
      shadow[wb_rd_addr] <= wb_rd_wdata;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 1; i < 32; i++) regs[i*XLEN +: XLEN] = shadow[i];
  end
`else
  assign regs = '0;
`endif

endmodule
